// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// Imported by the top level; fs_cell has no package dependencies.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of STEP-bit slices needed to cover WIDTH bits.
  function automatic int slice_count(input int width, input int step);
    return width / step;
  endfunction

  // Slice counter width, never narrower than one bit.
  function automatic int cnt_width(input int width, input int step);
    int n;
    n = width / step;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: d = a - b - c, bo is the borrow out.
// Chained STEP times per clock by serial_subtractor.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ c;
  assign bo = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin over WIDTH bits, STEP bits per clock, with
// valid/ready on both sides and borrow/zero/signed-overflow flags.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSLICE = slice_count(WIDTH, STEP);
  localparam int CW     = cnt_width(WIDTH, STEP);

  generate
    if (WIDTH < 1 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_params
      $error("serial_subtractor: need 1 <= STEP <= WIDTH and WIDTH %% STEP == 0");
    end
  endgenerate

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             a_msb, b_msb;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [STEP-1:0]  chain_d;
  logic [STEP:0]    chain_b;
  logic [WIDTH-1:0] diff_next;

  assign last = (cnt == CW'(NSLICE - 1));

  // Ripple-borrow chain over the current slice, seeded by the registered borrow.
  assign chain_b[0] = borrow;
  generate
    for (genvar i = 0; i < STEP; i++) begin : g_cell
      fs_cell u_cell (
        .a  (a_sh[i]),
        .b  (b_sh[i]),
        .c  (chain_b[i]),
        .d  (chain_d[i]),
        .bo (chain_b[i+1])
      );
    end
  endgenerate

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    diff_next = diff;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) diff_next[k*STEP +: STEP] = chain_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = RUN;
      RUN:     if (last)      next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      borrow    <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            borrow <= bin;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> STEP;
          b_sh   <= b_sh >> STEP;
          borrow <= chain_b[STEP];
          diff   <= diff_next;
          if (last) begin
            // Flags come from the completed result on the same edge it is written.
            bout <= chain_b[STEP];
            zero <= (diff_next == '0);
            ovf  <= (a_msb != b_msb) && (diff_next[WIDTH-1] != a_msb);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: three instances (STEP = 1, 4, 8) at WIDTH = 8,
// checked against an arithmetic reference of a - b - bin.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic [7:0] a, b;
  logic       bin;
  logic [2:0] in_valid, out_ready;
  logic [2:0] in_ready, out_valid, bout, zero, ovf;
  logic [7:0] diff [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  serial_subtractor #(.WIDTH(8), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .diff(diff[0]), .bout(bout[0]), .zero(zero[0]), .ovf(ovf[0]));

  serial_subtractor #(.WIDTH(8), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .diff(diff[1]), .bout(bout[1]), .zero(zero[1]), .ovf(ovf[1]));

  serial_subtractor #(.WIDTH(8), .STEP(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .diff(diff[2]), .bout(bout[2]), .zero(zero[2]), .ovf(ovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: {ovf, zero, bout, diff} from plain integer arithmetic.
  function automatic logic [10:0] model(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    int         r;
    logic [7:0] d;
    r = int'(av) - int'(bv) - int'(bi);
    d = r[7:0];
    return {(av[7] != bv[7]) && (d[7] != av[7]), d == 8'h00, r < 0, d};
  endfunction

  // Offer operands to instance idx until accepted; returns the accept cycle.
  task automatic start(input int idx, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       output int acc_cyc);
    bit ok;
    ok = 0;
    a = av; b = bv; bin = bi;
    in_valid[idx] = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready[idx]) ok = 1;
      @(posedge clk); #1;
    end
    acc_cyc = cyc;
    in_valid[idx] = 1'b0;
    check($sformatf("accept_s%0d", idx), ok, 1'b1);
  endtask

  task automatic wait_done(input int idx, output int lat);
    lat = 0;
    while (!out_valid[idx] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input int idx, input string tag, input logic [7:0] av,
                              input logic [7:0] bv, input logic bi);
    logic [10:0] m;
    m = model(av, bv, bi);
    check({tag, "_valid"}, out_valid[idx], 1'b1);
    check({tag, "_diff"},  diff[idx],      m[7:0]);
    check({tag, "_bout"},  bout[idx],      m[8]);
    check({tag, "_zero"},  zero[idx],      m[9]);
    check({tag, "_ovf"},   ovf[idx],       m[10]);
  endtask

  task automatic handshake(input int idx);
    out_ready[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready[idx] = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_diff_s%0d", tag, i),  diff[i],      8'h00);
      check($sformatf("%s_flags_s%0d", tag, i), {bout[i], zero[i], ovf[i], out_valid[i]}, 4'b0000);
      check($sformatf("%s_ready_s%0d", tag, i), in_ready[i],  1'b1);
    end
  endtask

  initial begin
    int          acc, prev_acc, lat;
    logic [7:0]  ra, rb;
    logic        rbi;
    logic [10:0] m;
    logic [7:0]  held_diff;
    logic [3:0]  held_flags;

    rst_n = 1'b0; in_valid = '0; out_ready = '0; a = '0; b = '0; bin = 1'b0;
    #2;
    check_cleared("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases on STEP=1, with spec-given constants and latency 8.
    start(0, 8'h5A, 8'h3C, 1'b0, acc);
    wait_done(0, lat);
    check("lat_s1", lat, 8);
    check("d1_diff", diff[0], 8'h1E);
    check("d1_flags", {bout[0], zero[0], ovf[0]}, 3'b000);
    handshake(0);
    check("d1_idle_valid", out_valid[0], 1'b0);
    check("d1_idle_ready", in_ready[0], 1'b1);

    start(0, 8'h00, 8'h01, 1'b0, acc);
    wait_done(0, lat);
    check("d2_diff", diff[0], 8'hFF);
    check("d2_bout_ovf", {bout[0], ovf[0]}, 2'b10);
    handshake(0);

    start(0, 8'h80, 8'h01, 1'b0, acc);
    wait_done(0, lat);
    check("d3_diff", diff[0], 8'h7F);
    check("d3_bout_ovf", {bout[0], ovf[0]}, 2'b01);
    handshake(0);

    start(0, 8'h10, 8'h0F, 1'b1, acc);
    wait_done(0, lat);
    check("d4_diff", diff[0], 8'h00);
    check("d4_zero_bout", {zero[0], bout[0]}, 2'b10);
    handshake(0);

    // Backpressure in DONE with new operands offered.
    start(0, 8'h33, 8'h11, 1'b0, acc);
    wait_done(0, lat);
    held_diff  = diff[0];
    held_flags = {bout[0], zero[0], ovf[0], out_valid[0]};
    check("bp_diff0", held_diff, 8'h22);
    a = 8'hAA; b = 8'h55; bin = 1'b1; in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_diff", diff[0], 8'h22);
      check("bp_flags", {bout[0], zero[0], ovf[0], out_valid[0]}, 4'b0001);
      check("bp_ready", in_ready[0], 1'b0);
    end
    handshake(0);
    check("bp_released", {out_valid[0], in_ready[0]}, 2'b01);
    check("bp_diff_kept", diff[0], 8'h22);
    start(0, 8'hAA, 8'h55, 1'b1, acc);
    wait_done(0, lat);
    check_result(0, "bp_new", 8'hAA, 8'h55, 1'b1);
    handshake(0);

    // Asynchronous reset three edges into RUN.
    start(0, 8'hFF, 8'h00, 1'b0, acc);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_cleared("midrun_rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    start(0, 8'h05, 8'h03, 1'b0, acc);
    wait_done(0, lat);
    check("post_rst_diff", diff[0], 8'h02);
    handshake(0);

    // out_ready held high outside DONE must not disturb an operation.
    out_ready[0] = 1'b1;
    start(0, 8'h01, 8'h02, 1'b0, acc);
    wait_done(0, lat);
    check("or_early_lat", lat, 8);
    check_result(0, "or_early", 8'h01, 8'h02, 1'b0);
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    // Random operands on STEP=4 and STEP=8, out_ready held high for full throughput.
    for (int idx = 1; idx < 3; idx++) begin
      out_ready[idx] = 1'b1;
      prev_acc = -1;
      for (int n = 0; n < 1000; n++) begin
        ra  = 8'($urandom);
        rb  = 8'($urandom);
        rbi = 1'($urandom);
        start(idx, ra, rb, rbi, acc);
        if (prev_acc >= 0) check($sformatf("tput_s%0d", idx), acc - prev_acc, (idx == 1) ? 4 : 3);
        prev_acc = acc;
        // Change inputs after accept; the running operation must not see it.
        a = ~ra; b = ~rb; bin = ~rbi;
        wait_done(idx, lat);
        check($sformatf("lat_s%0d", idx), lat, (idx == 1) ? 2 : 1);
        m = model(ra, rb, rbi);
        check($sformatf("rnd_diff_s%0d", idx), diff[idx], m[7:0]);
        check($sformatf("rnd_bout_s%0d", idx), bout[idx], m[8]);
        check($sformatf("rnd_zero_s%0d", idx), zero[idx], m[9]);
        check($sformatf("rnd_ovf_s%0d", idx),  ovf[idx],  m[10]);
      end
      @(posedge clk); #1;
      out_ready[idx] = 1'b0;
    end

    // A shorter random run on STEP=1 with backpressure handshakes.
    for (int n = 0; n < 100; n++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rbi = 1'($urandom);
      start(0, ra, rb, rbi, acc);
      wait_done(0, lat);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      check_result(0, "rnd_s1", ra, rb, rbi);
      handshake(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor computing `a - b - bin` over WIDTH bits, STEP bits per clock, using a chain of full-subtractor cells and a registered borrow. It extends the team's combinational full subtractor into a handshaked datapath unit with selectable width and throughput. It adds borrow-out, zero and signed-overflow flags. It sits between an operand producer and a result consumer using valid/ready on both sides.

## Interface
- `WIDTH`, default 8: operand and result width; must be ≥ 1.
- `STEP`, default 1: bits processed per clock; 1 ≤ STEP ≤ WIDTH and WIDTH % STEP == 0, otherwise elaboration error.
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result.
- `diff`  out  WIDTH  `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1  borrow-out; 1 iff `a < b + bin` (unsigned).
- `zero`  out  1  `diff == 0`.
- `ovf`  out  1  signed overflow: `a[W-1] != b[W-1]` and `diff[W-1] != a[W-1]`.

## Operation
- FSM states:
  - IDLE: `in_ready = 1`.
  - RUN: processes one slice per cycle.
  - DONE: `out_valid = 1`.
- IDLE → RUN on `in_valid && in_ready`:
  - latch `a` and `b` into shift registers;
  - borrow register ← `bin`;
  - slice counter ← 0;
  - clear the result register and flags.
- RUN, each edge:
  - slice k, bits `[k*STEP +: STEP]`, passes through the STEP-cell chain with the registered borrow as chain input;
  - difference bits are written into the result;
  - borrow register ← chain output;
  - counter increments.
- RUN → DONE on the edge that processes the last slice (k = WIDTH/STEP − 1):
  - `bout` ← final borrow;
  - `zero` and `ovf` are computed from the completed result and registered on that same edge.
- DONE → IDLE on `out_ready`. Result outputs keep their value after leaving DONE; they are valid only while `out_valid` is high.
- `in_ready` is asserted only in IDLE. `in_valid` in RUN or DONE is ignored, and the operands are not captured.
- `a`, `b`, `bin` are sampled only at the accept edge. Later input changes do not affect the running operation.
- All outputs are registered except `in_ready`, which decodes the state.

## Timing
- Reset (`rst_n` low, any state, including mid-RUN), applied immediately:
  - state = IDLE;
  - `diff = 0`, `bout = 0`, `zero = 0`, `ovf = 0`, `out_valid = 0`;
  - borrow register = 0, counter = 0;
  - `in_ready = 1`.
- Latency: with accept at edge E, `out_valid` rises at edge E + WIDTH/STEP.
- STEP = WIDTH gives 1-cycle latency, still passing through one RUN cycle.
- Throughput is one operation per WIDTH/STEP + 2 cycles when `out_ready` is held high. The +2 comes from the DONE handshake edge plus the IDLE accept.
- Backpressure: while DONE and `out_ready` is low, `diff`, `bout`, `zero`, `ovf`, `out_valid` are held stable indefinitely.
- `out_ready` asserted outside DONE has no effect.
- The counter width is `$clog2(WIDTH/STEP)`, minimum 1; the counter does not wrap past the last slice.

## Structure
- Shared package `serial_sub_pkg`:
  - state typedef (IDLE, RUN, DONE);
  - localparam helper for the slice count.
- Sub-module `fs_cell`, a 1-bit full subtractor:
  - `d = a ^ b ^ c`;
  - `bo = (~a & b) | (~(a ^ b) & c)`.
- STEP instances of `fs_cell` are chained via a generate loop inside `serial_subtractor`.
- Top level holds the FSM, the shift registers, the borrow register and flag logic.

## Test plan
- WIDTH=8, STEP=1, `a=0x5A`, `b=0x3C`, `bin=0` → `diff=0x1E`, `bout=0`, `zero=0`, `ovf=0`; `out_valid` exactly 8 edges after accept.
- `a=0x00`, `b=0x01`, `bin=0` → `diff=0xFF`, `bout=1`, `ovf=0`; then `a=0x80`, `b=0x01` → `diff=0x7F`, `bout=0`, `ovf=1`.
- `a=0x10`, `b=0x0F`, `bin=1` → `diff=0x00`, `zero=1`, `bout=0`.
- Hold `out_ready=0` for 5 cycles in DONE while driving `in_valid=1` with new operands:
  - outputs remain stable and `in_ready=0`;
  - the new operands are not captured;
  - after `out_ready`, the next accept yields the new result.
- Assert `rst_n` low 3 edges into RUN → all outputs 0 and `in_ready=1` immediately; the next operation `0x05 − 0x03` gives `diff=0x02`.
- STEP=4 and STEP=8 with WIDTH=8:
  - latency is 2 and 1 edges respectively;
  - 1000 random `{a, b, bin}` match a reference `a − b − bin` on `diff`, `bout`, `zero`, `ovf`.
